wb_arb: RTL and testbench

Writeback arbiter that terminates the execution-pipeline-to-writeback handshake for both the integer pipeline and the load/store pipeline. Each source pushes completed results into a private 2-entry FIFO. A round-robin arbiter retires one result per cycle onto the single register-file write port and the retire/forwarding bus. The block also keeps the 64-bit retired-instruction counter.

---
 rtl/wb_arb.sv | 109 ++++++++++
 tb/tb_wb_arb.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arb.sv
`default_nettype none
// wb_arb: writeback arbiter. Two 2-entry result FIFOs (integer and load/store
// pipes) drained round-robin onto one register-file write port and retire bus.
module wb_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ip_wb_dst,
  input  logic [63:0] ip_wb_result,
  input  logic [63:0] ip_wb_pc,
  input  logic        ip_wb_wb_en,
  input  logic        ip_wb_valid,
  output logic        ip_wb_ready,
  input  logic [4:0]  lsp_wb_dst,
  input  logic [63:0] lsp_wb_result,
  input  logic [63:0] lsp_wb_pc,
  input  logic        lsp_wb_wb_en,
  input  logic        lsp_wb_valid,
  output logic        lsp_wb_ready,
  output logic        rf_wr_en,
  output logic [4:0]  rf_wr_id,
  output logic [63:0] rf_wr_data,
  output logic        wb_retire_valid,
  output logic [63:0] wb_retire_pc,
  output logic [63:0] wb_instret
);
  // Entry layout: {dst[133:129], result[128:65], pc[64:1], wb_en[0]}
  localparam int EW = 134;

  logic [EW-1:0] ip_mem_q  [2];
  logic [EW-1:0] lsp_mem_q [2];
  logic          ip_wp_q, ip_rp_q, lsp_wp_q, lsp_rp_q;
  logic [1:0]    ip_cnt_q, lsp_cnt_q;
  logic          prio_q, prio_d;
  logic          ip_push, lsp_push, ip_req, lsp_req;
  logic          gnt_ip, gnt_lsp, gnt;
  logic [EW-1:0] ip_head, lsp_head, head;

  assign ip_wb_ready  = (ip_cnt_q  < 2'd2);
  assign lsp_wb_ready = (lsp_cnt_q < 2'd2);
  assign ip_push      = ip_wb_valid  && ip_wb_ready;
  assign lsp_push     = lsp_wb_valid && lsp_wb_ready;
  assign ip_req       = (ip_cnt_q  != 2'd0);
  assign lsp_req      = (lsp_cnt_q != 2'd0);
  assign ip_head      = ip_mem_q[ip_rp_q];
  assign lsp_head     = lsp_mem_q[lsp_rp_q];
  assign gnt          = gnt_ip || gnt_lsp;

  always_comb begin
    gnt_ip  = 1'b0;
    gnt_lsp = 1'b0;
    prio_d  = prio_q;
    head    = ip_head;
    if (ip_req && (!lsp_req || !prio_q)) begin
      gnt_ip = 1'b1;
      prio_d = 1'b1;
    end else if (lsp_req) begin
      gnt_lsp = 1'b1;
      prio_d  = 1'b0;
      head    = lsp_head;
    end
  end

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (ip_push)  ip_mem_q[ip_wp_q]   <= {ip_wb_dst, ip_wb_result, ip_wb_pc, ip_wb_wb_en};
    if (lsp_push) lsp_mem_q[lsp_wp_q] <= {lsp_wb_dst, lsp_wb_result, lsp_wb_pc, lsp_wb_wb_en};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ip_wp_q   <= 1'b0;
      ip_rp_q   <= 1'b0;
      ip_cnt_q  <= 2'd0;
      lsp_wp_q  <= 1'b0;
      lsp_rp_q  <= 1'b0;
      lsp_cnt_q <= 2'd0;
      prio_q    <= 1'b0;
    end else begin
      if (ip_push)  ip_wp_q  <= ~ip_wp_q;
      if (gnt_ip)   ip_rp_q  <= ~ip_rp_q;
      if (lsp_push) lsp_wp_q <= ~lsp_wp_q;
      if (gnt_lsp)  lsp_rp_q <= ~lsp_rp_q;
      ip_cnt_q  <= ip_cnt_q  + 2'(ip_push)  - 2'(gnt_ip);
      lsp_cnt_q <= lsp_cnt_q + 2'(lsp_push) - 2'(gnt_lsp);
      prio_q    <= prio_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_retire_valid <= 1'b0;
      rf_wr_en        <= 1'b0;
      rf_wr_id        <= 5'd0;
      rf_wr_data      <= 64'd0;
      wb_retire_pc    <= 64'd0;
      wb_instret      <= 64'd0;
    end else begin
      wb_retire_valid <= gnt;
      rf_wr_en        <= gnt && head[0] && (head[133:129] != 5'd0);
      if (gnt) begin
        rf_wr_id     <= head[133:129];
        rf_wr_data   <= head[128:65];
        wb_retire_pc <= head[64:1];
        wb_instret   <= wb_instret + 64'd1;
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_wb_arb.sv
`default_nettype none
// tb_wb_arb: directed self-checking bench for the writeback arbiter.
module tb_wb_arb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  ip_wb_dst = '0, lsp_wb_dst = '0;
  logic [63:0] ip_wb_result = '0, ip_wb_pc = '0, lsp_wb_result = '0, lsp_wb_pc = '0;
  logic        ip_wb_wb_en = 1'b0, ip_wb_valid = 1'b0, lsp_wb_wb_en = 1'b0, lsp_wb_valid = 1'b0;
  logic        ip_wb_ready, lsp_wb_ready, rf_wr_en, wb_retire_valid;
  logic [4:0]  rf_wr_id;
  logic [63:0] rf_wr_data, wb_retire_pc, wb_instret;

  int tests = 0;
  int fails = 0;
  logic [63:0] exp_ret = '0;

  wb_arb dut (
    .clk(clk), .rst(rst),
    .ip_wb_dst(ip_wb_dst), .ip_wb_result(ip_wb_result), .ip_wb_pc(ip_wb_pc),
    .ip_wb_wb_en(ip_wb_wb_en), .ip_wb_valid(ip_wb_valid), .ip_wb_ready(ip_wb_ready),
    .lsp_wb_dst(lsp_wb_dst), .lsp_wb_result(lsp_wb_result), .lsp_wb_pc(lsp_wb_pc),
    .lsp_wb_wb_en(lsp_wb_wb_en), .lsp_wb_valid(lsp_wb_valid), .lsp_wb_ready(lsp_wb_ready),
    .rf_wr_en(rf_wr_en), .rf_wr_id(rf_wr_id), .rf_wr_data(rf_wr_data),
    .wb_retire_valid(wb_retire_valid), .wb_retire_pc(wb_retire_pc), .wb_instret(wb_instret)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ip_wb_valid  = 1'b0;
    lsp_wb_valid = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1;
    @(negedge clk);
    tests++; if (wb_retire_valid !== 1'b0) begin fails++; $display("FAIL reset_retire_valid got %0h want 0", wb_retire_valid); end
    tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL reset_rf_wr_en got %0h want 0", rf_wr_en); end
    tests++; if (rf_wr_id !== 5'd0) begin fails++; $display("FAIL reset_rf_wr_id got %0h want 0", rf_wr_id); end
    tests++; if (rf_wr_data !== 64'd0) begin fails++; $display("FAIL reset_rf_wr_data got %0h want 0", rf_wr_data); end
    tests++; if (wb_retire_pc !== 64'd0) begin fails++; $display("FAIL reset_retire_pc got %0h want 0", wb_retire_pc); end
    tests++; if (wb_instret !== 64'd0) begin fails++; $display("FAIL reset_instret got %0h want 0", wb_instret); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (ip_wb_ready !== 1'b1) begin fails++; $display("FAIL reset_ip_ready got %0h want 1", ip_wb_ready); end
    tests++; if (lsp_wb_ready !== 1'b1) begin fails++; $display("FAIL reset_lsp_ready got %0h want 1", lsp_wb_ready); end
    exp_ret = 64'd0;
  endtask

  task automatic test_single();
    ip_wb_dst = 5'd5; ip_wb_result = 64'h1234; ip_wb_pc = 64'h8000_0000; ip_wb_wb_en = 1'b1;
    ip_wb_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    tests++; if (wb_retire_valid !== 1'b0) begin fails++; $display("FAIL single_no_bypass got %0h want 0", wb_retire_valid); end
    @(negedge clk);
    exp_ret = exp_ret + 64'd1;
    tests++; if (wb_retire_valid !== 1'b1) begin fails++; $display("FAIL single_retire_valid got %0h want 1", wb_retire_valid); end
    tests++; if (rf_wr_en !== 1'b1) begin fails++; $display("FAIL single_wr_en got %0h want 1", rf_wr_en); end
    tests++; if (rf_wr_id !== 5'd5) begin fails++; $display("FAIL single_wr_id got %0h want 5", rf_wr_id); end
    tests++; if (rf_wr_data !== 64'h1234) begin fails++; $display("FAIL single_wr_data got %0h want 1234", rf_wr_data); end
    tests++; if (wb_retire_pc !== 64'h8000_0000) begin fails++; $display("FAIL single_pc got %0h want 80000000", wb_retire_pc); end
    tests++; if (wb_instret !== exp_ret) begin fails++; $display("FAIL single_instret got %0h want %0h", wb_instret, exp_ret); end
    @(negedge clk);
    tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL single_wr_en_drop got %0h want 0", rf_wr_en); end
    tests++; if (wb_retire_valid !== 1'b0) begin fails++; $display("FAIL single_valid_drop got %0h want 0", wb_retire_valid); end
    tests++; if (rf_wr_id !== 5'd5) begin fails++; $display("FAIL single_id_hold got %0h want 5", rf_wr_id); end
    tests++; if (rf_wr_data !== 64'h1234) begin fails++; $display("FAIL single_data_hold got %0h want 1234", rf_wr_data); end
  endtask

  task automatic test_x0();
    lsp_wb_dst = 5'd0; lsp_wb_result = 64'hDEAD; lsp_wb_pc = 64'h3000; lsp_wb_wb_en = 1'b1;
    lsp_wb_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    idle();
    @(negedge clk);
    exp_ret = exp_ret + 64'd1;
    tests++; if (wb_retire_valid !== 1'b1) begin fails++; $display("FAIL x0_retire_valid got %0h want 1", wb_retire_valid); end
    tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL x0_wr_en got %0h want 0", rf_wr_en); end
    tests++; if (wb_retire_pc !== 64'h3000) begin fails++; $display("FAIL x0_pc got %0h want 3000", wb_retire_pc); end
    tests++; if (wb_instret !== exp_ret) begin fails++; $display("FAIL x0_instret got %0h want %0h", wb_instret, exp_ret); end
  endtask

  task automatic test_lsp_stream();
    for (int i = 0; i < 10; i++) begin
      if (i < 8) begin
        lsp_wb_dst = 5'(i + 1); lsp_wb_result = 64'hC000 + 64'(i);
        lsp_wb_pc = 64'h4000 + 64'(i * 8); lsp_wb_wb_en = 1'b1; lsp_wb_valid = 1'b1;
        tests++; if (lsp_wb_ready !== 1'b1) begin fails++; $display("FAIL lsp_stream_ready i=%0d got %0h want 1", i, lsp_wb_ready); end
      end else begin
        lsp_wb_valid = 1'b0;
      end
      if (i >= 2) begin
        tests++; if (wb_retire_valid !== 1'b1) begin fails++; $display("FAIL lsp_stream_valid i=%0d got %0h want 1", i, wb_retire_valid); end
        tests++; if (wb_retire_pc !== 64'h4000 + 64'((i - 2) * 8)) begin fails++; $display("FAIL lsp_stream_pc i=%0d got %0h want %0h", i, wb_retire_pc, 64'h4000 + 64'((i - 2) * 8)); end
        tests++; if (rf_wr_data !== 64'hC000 + 64'(i - 2)) begin fails++; $display("FAIL lsp_stream_data i=%0d got %0h want %0h", i, rf_wr_data, 64'hC000 + 64'(i - 2)); end
      end
      @(posedge clk);
      @(negedge clk);
    end
    exp_ret = exp_ret + 64'd8;
    tests++; if (wb_instret !== exp_ret) begin fails++; $display("FAIL lsp_stream_instret got %0h want %0h", wb_instret, exp_ret); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] got_pc [$];
    logic [4:0]  got_id [$];
    logic [63:0] got_data [$];
    int ii = 0, li = 0;
    bit ifire = 0, lfire = 0, ip_low = 0, lsp_low = 0;
    rst = 1'b1;
    idle();
    @(negedge clk);
    rst = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (wb_retire_valid === 1'b1) begin
        got_pc.push_back(wb_retire_pc);
        got_id.push_back(rf_wr_id);
        got_data.push_back(rf_wr_data);
      end
      if (ifire) ii++;
      if (lfire) li++;
      ip_wb_valid = (ii < 6);
      ip_wb_dst = 5'(1 + ii); ip_wb_result = 64'hA000 + 64'(ii); ip_wb_pc = 64'h1000 + 64'(ii * 4); ip_wb_wb_en = 1'b1;
      lsp_wb_valid = (li < 6);
      lsp_wb_dst = 5'(10 + li); lsp_wb_result = 64'hB000 + 64'(li); lsp_wb_pc = 64'h2000 + 64'(li * 4); lsp_wb_wb_en = 1'b1;
      if (ip_wb_ready === 1'b0) ip_low = 1;
      if (lsp_wb_ready === 1'b0) lsp_low = 1;
      ifire = ip_wb_valid && (ip_wb_ready === 1'b1);
      lfire = lsp_wb_valid && (lsp_wb_ready === 1'b1);
      @(posedge clk);
      @(negedge clk);
    end
    idle();
    tests++; if (got_pc.size() != 12) begin fails++; $display("FAIL b2b_retire_count got %0d want 12", got_pc.size()); end
    for (int k = 0; k < 12 && k < got_pc.size(); k++) begin
      logic [63:0] epc, edata;
      logic [4:0]  eid;
      if (k % 2 == 0) begin
        epc = 64'h1000 + 64'((k / 2) * 4); eid = 5'(1 + k / 2); edata = 64'hA000 + 64'(k / 2);
      end else begin
        epc = 64'h2000 + 64'((k / 2) * 4); eid = 5'(10 + k / 2); edata = 64'hB000 + 64'(k / 2);
      end
      tests++; if (got_pc[k] !== epc) begin fails++; $display("FAIL b2b_order_pc k=%0d got %0h want %0h", k, got_pc[k], epc); end
      tests++; if (got_id[k] !== eid) begin fails++; $display("FAIL b2b_order_id k=%0d got %0h want %0h", k, got_id[k], eid); end
      tests++; if (got_data[k] !== edata) begin fails++; $display("FAIL b2b_order_data k=%0d got %0h want %0h", k, got_data[k], edata); end
    end
    tests++; if (wb_instret !== 64'd12) begin fails++; $display("FAIL b2b_instret got %0h want c", wb_instret); end
    tests++; if (!ip_low) begin fails++; $display("FAIL b2b_ip_ready_drop got 0 want 1"); end
    tests++; if (!lsp_low) begin fails++; $display("FAIL b2b_lsp_ready_drop got 0 want 1"); end
  endtask

  task automatic test_async_reset();
    ip_wb_dst = 5'd7; ip_wb_result = 64'h77; ip_wb_pc = 64'h7000; ip_wb_wb_en = 1'b1; ip_wb_valid = 1'b1;
    lsp_wb_dst = 5'd8; lsp_wb_result = 64'h88; lsp_wb_pc = 64'h8000; lsp_wb_wb_en = 1'b1; lsp_wb_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      @(negedge clk);
    end
    tests++; if (wb_retire_valid !== 1'b1) begin fails++; $display("FAIL arst_pre_valid got %0h want 1", wb_retire_valid); end
    #2;
    rst = 1'b1;
    #1;
    tests++; if (rf_wr_en !== 1'b0) begin fails++; $display("FAIL arst_wr_en got %0h want 0", rf_wr_en); end
    tests++; if (wb_retire_valid !== 1'b0) begin fails++; $display("FAIL arst_valid got %0h want 0", wb_retire_valid); end
    tests++; if (wb_instret !== 64'd0) begin fails++; $display("FAIL arst_instret got %0h want 0", wb_instret); end
    idle();
    @(negedge clk);
    rst = 1'b0;
    tests++; if (ip_wb_ready !== 1'b1) begin fails++; $display("FAIL arst_ip_ready got %0h want 1", ip_wb_ready); end
    tests++; if (lsp_wb_ready !== 1'b1) begin fails++; $display("FAIL arst_lsp_ready got %0h want 1", lsp_wb_ready); end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      tests++; if (wb_retire_valid !== 1'b0) begin fails++; $display("FAIL arst_stale_retire c=%0d got %0h want 0", c, wb_retire_valid); end
    end
    tests++; if (wb_instret !== 64'd0) begin fails++; $display("FAIL arst_instret_after got %0h want 0", wb_instret); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_x0();
    test_lsp_stream();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
`default_nettype wire
